// File: rtl/axi_spi_cmd_bridge.sv
// AXI4-Lite slave front end for the SPI shift engine: one command in flight.
// Optional engine-response timeout: define SPI_BRIDGE_TIMEOUT_EN.
//
// Ports:
//  ACLK, ARESET              clock, async active-high reset
//  AW*/W*/B*                 AXI4-Lite write address/data/response
//  AR*/R*                    AXI4-Lite read address/data
//  cmd_valid/ready/write/data  command to engine (valid/ready)
//  rsp_valid/rsp_data          one-cycle engine completion
module axi_spi_cmd_bridge #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WR_SEL_BIT  = 24,
  parameter int RD_SEL_BIT  = 25,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [2:0]        AWPROT,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic              WVALID,
  output logic              WREADY,
  output logic              BVALID,
  output logic [1:0]        BRESP,
  input  logic              BREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic              ARVALID,
  output logic              ARREADY,
  input  logic [2:0]        ARPROT,
  output logic              RVALID,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  input  logic              RREADY,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_write,
  output logic [DATA_W-1:0] cmd_data,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_data
);

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [9:0] TO_LIM = 10'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, WR_ISSUE, WR_WAIT, WR_RESP,
    RD_ISSUE, RD_WAIT, RD_RESP
  } state_t;

  state_t state;

  logic              aw_full, w_full, ar_full;
  logic              aw_sel, ar_sel, w_strb_ok;
  logic [DATA_W-1:0] w_data;
  logic              idle, wr_done, rd_done;
  logic              unused_ok;

  assign idle    = (state == IDLE);
  // Reset is folded in so READY is low while ARESET is held.
  assign AWREADY = !ARESET && idle && !aw_full;
  assign WREADY  = !ARESET && idle && !w_full;
  assign ARREADY = !ARESET && idle && !ar_full;

  assign wr_done = (state == WR_RESP) && BREADY;
  assign rd_done = (state == RD_RESP) && RREADY;

  // Only the window-select bits and a strobe summary are kept.
  assign unused_ok = ^{AWADDR, ARADDR, AWPROT, ARPROT, TO_LIM};

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      ar_full   <= 1'b0;
      aw_sel    <= 1'b0;
      ar_sel    <= 1'b0;
      w_strb_ok <= 1'b0;
      w_data    <= '0;
    end else begin
      if (AWVALID && AWREADY) begin
        aw_full <= 1'b1;
        aw_sel  <= AWADDR[WR_SEL_BIT];
      end else if (wr_done) begin
        aw_full <= 1'b0;
      end
      if (WVALID && WREADY) begin
        w_full    <= 1'b1;
        w_data    <= WDATA;
        w_strb_ok <= &WSTRB;
      end else if (wr_done) begin
        w_full <= 1'b0;
      end
      if (ARVALID && ARREADY) begin
        ar_full <= 1'b1;
        ar_sel  <= ARADDR[RD_SEL_BIT];
      end else if (rd_done) begin
        ar_full <= 1'b0;
      end
    end
  end

`ifdef SPI_BRIDGE_TIMEOUT_EN
  logic [9:0] to_cnt;
  logic       to_hit;
  assign to_hit = (to_cnt == TO_LIM);
`endif

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state     <= IDLE;
      cmd_valid <= 1'b0;
      cmd_write <= 1'b0;
      cmd_data  <= '0;
      BVALID    <= 1'b0;
      BRESP     <= OKAY;
      RVALID    <= 1'b0;
      RRESP     <= OKAY;
      RDATA     <= '0;
`ifdef SPI_BRIDGE_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          // Writes win when both directions are buffered.
          if (aw_full && w_full) begin
            if (aw_sel && w_strb_ok) begin
              state     <= WR_ISSUE;
              cmd_valid <= 1'b1;
              cmd_write <= 1'b1;
              cmd_data  <= w_data;
            end else begin
              state  <= WR_RESP;
              BVALID <= 1'b1;
              BRESP  <= SLVERR;
            end
          end else if (ar_full) begin
            if (ar_sel) begin
              state     <= RD_ISSUE;
              cmd_valid <= 1'b1;
              cmd_write <= 1'b0;
              cmd_data  <= '0;
            end else begin
              state  <= RD_RESP;
              RVALID <= 1'b1;
              RRESP  <= SLVERR;
              RDATA  <= '0;
            end
          end
        end
        WR_ISSUE, RD_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= (state == WR_ISSUE) ? WR_WAIT : RD_WAIT;
`ifdef SPI_BRIDGE_TIMEOUT_EN
            to_cnt    <= '0;
`endif
          end
        end
        WR_WAIT: begin
`ifdef SPI_BRIDGE_TIMEOUT_EN
          to_cnt <= to_cnt + 10'd1;
`endif
          if (rsp_valid) begin
            state  <= WR_RESP;
            BVALID <= 1'b1;
            BRESP  <= OKAY;
          end
`ifdef SPI_BRIDGE_TIMEOUT_EN
          else if (to_hit) begin
            state  <= WR_RESP;
            BVALID <= 1'b1;
            BRESP  <= SLVERR;
          end
`endif
        end
        RD_WAIT: begin
`ifdef SPI_BRIDGE_TIMEOUT_EN
          to_cnt <= to_cnt + 10'd1;
`endif
          if (rsp_valid) begin
            state  <= RD_RESP;
            RVALID <= 1'b1;
            RRESP  <= OKAY;
            RDATA  <= rsp_data;
          end
`ifdef SPI_BRIDGE_TIMEOUT_EN
          else if (to_hit) begin
            state  <= RD_RESP;
            RVALID <= 1'b1;
            RRESP  <= SLVERR;
            RDATA  <= '0;
          end
`endif
        end
        WR_RESP: begin
          if (BREADY) begin
            BVALID <= 1'b0;
            state  <= IDLE;
          end
        end
        RD_RESP: begin
          if (RREADY) begin
            RVALID <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_spi_cmd_bridge.sv
// Scoreboard bench for axi_spi_cmd_bridge.
// Commands and responses are queued on stimulus and popped on DUT output.
`timescale 1ns/1ps
module tb_axi_spi_cmd_bridge;

`ifdef SPI_BRIDGE_TIMEOUT_EN
  localparam int TO     = 8;
  localparam int LONG_E = 5;
`else
  localparam int TO     = 1023;
  localparam int LONG_E = 40;
`endif

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [31:0] AWADDR = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [2:0]  AWPROT = '0;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic        BVALID;
  logic [1:0]  BRESP;
  logic        BREADY = 1'b0;
  logic [31:0] ARADDR = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [2:0]  ARPROT = '0;
  logic        RVALID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RREADY = 1'b0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic        cmd_write;
  logic [31:0] cmd_data;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;

  always #5 ACLK = ~ACLK;

  axi_spi_cmd_bridge #(.TIMEOUT_CYC(TO)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY), .AWPROT(AWPROT),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY), .ARPROT(ARPROT),
    .RVALID(RVALID), .RDATA(RDATA), .RRESP(RRESP), .RREADY(RREADY),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data)
  );

  typedef struct packed {
    logic        rd;
    logic [1:0]  resp;
    logic [31:0] data;
  } rsp_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] data;
  } cmd_t;

  rsp_t exp_rsp[$];
  cmd_t exp_cmd[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int eng_delay = 1;
  bit eng_en = 1'b1;
  logic [31:0] eng_data = '0;
  int cd = -1;
  bit stray = 1'b0;
  int rsp_cyc = 0;
  int hs_cyc = 0;
  int hs_cnt = 0;
  int cv_cnt = 0;
  cmd_t e_cmd;

  always @(posedge ACLK) cyc <= cyc + 1;

  function automatic void exp_r(logic rd, logic [1:0] r, logic [31:0] d);
    exp_rsp.push_back({rd, r, d});
  endfunction

  function automatic void exp_c(logic wr, logic [31:0] d);
    exp_cmd.push_back({wr, d});
  endfunction

  // Engine model: checks each accepted command and answers after eng_delay.
  always @(negedge ACLK) begin
    rsp_valid = 1'b0;
    if (ARESET) begin
      cd = -1;
    end else begin
      if (cd == 0 || stray) begin
        rsp_valid = 1'b1;
        rsp_data  = eng_data;
        rsp_cyc   = cyc;
        cd        = -1;
        stray     = 1'b0;
      end else if (cd > 0) begin
        cd--;
      end
      if (cmd_valid) cv_cnt++;
      if (cmd_valid && cmd_ready) begin
        hs_cnt++;
        hs_cyc = cyc;
        n_cmp++;
        if (exp_cmd.size() == 0) begin
          n_bad++;
          $display("FAIL cmd_unexpected: got write=%0b data=%h, required no command",
                   cmd_write, cmd_data);
        end else begin
          e_cmd = exp_cmd.pop_front();
          if ({cmd_write, cmd_data} !== e_cmd) begin
            n_bad++;
            $display("FAIL cmd: got write=%0b data=%h, required write=%0b data=%h",
                     cmd_write, cmd_data, e_cmd.wr, e_cmd.data);
          end
        end
        if (eng_en) cd = eng_delay - 1;
      end
    end
  end

  task automatic axi_req(input bit do_aw, input bit do_w, input bit do_ar,
                         input logic [31:0] awa, input logic [31:0] wd,
                         input logic [3:0] ws, input logic [31:0] ara);
    bit ad, wdn, rdn;
    ad = !do_aw;
    wdn = !do_w;
    rdn = !do_ar;
    AWADDR = awa;
    WDATA = wd;
    WSTRB = ws;
    ARADDR = ara;
    AWVALID = do_aw;
    WVALID = do_w;
    ARVALID = do_ar;
    for (int i = 0; i < 50; i++) begin
      if (ad && wdn && rdn) break;
      if (AWVALID && AWREADY) ad = 1'b1;
      if (WVALID && WREADY) wdn = 1'b1;
      if (ARVALID && ARREADY) rdn = 1'b1;
      @(negedge ACLK);
      if (ad) AWVALID = 1'b0;
      if (wdn) WVALID = 1'b0;
      if (rdn) ARVALID = 1'b0;
    end
    if (!(ad && wdn && rdn)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL axi_handshake: got aw=%0b w=%0b ar=%0b, required all 1",
               ad, wdn, rdn);
      AWVALID = 1'b0;
      WVALID = 1'b0;
      ARVALID = 1'b0;
    end
  endtask

  task automatic collect_rsp(input int budget, input int hold, output int seen);
    rsp_t e;
    rsp_t g;
    bit got;
    logic [34:0] h;
    got = 1'b0;
    seen = -1;
    for (int i = 0; i < budget; i++) begin
      if (BVALID || RVALID) begin
        got = 1'b1;
        break;
      end
      @(negedge ACLK);
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL rsp_timeout: got no BVALID/RVALID, required one in %0d cycles",
               budget);
      return;
    end
    seen = cyc;
    g.rd = RVALID;
    g.resp = RVALID ? RRESP : BRESP;
    g.data = RVALID ? RDATA : 32'h0;
    if (exp_rsp.size() == 0) begin
      n_bad++;
      $display("FAIL rsp_unexpected: got rd=%0b resp=%b data=%h, required none",
               g.rd, g.resp, g.data);
    end else begin
      e = exp_rsp.pop_front();
      if (g !== e) begin
        n_bad++;
        $display("FAIL rsp: got rd=%0b resp=%b data=%h, required rd=%0b resp=%b data=%h",
                 g.rd, g.resp, g.data, e.rd, e.resp, e.data);
      end
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge ACLK);
      h = g.rd ? {RVALID, RRESP, RDATA} : {BVALID, BRESP, 32'h0};
      n_cmp++;
      if (h !== {1'b1, g.resp, g.data} ||
          {cmd_valid, AWREADY, WREADY, ARREADY} !== 4'b0000) begin
        n_bad++;
        $display("FAIL rsp_hold: got %h cv=%0b rdy=%b%b%b, required %h cv=0 rdy=000",
                 h, cmd_valid, AWREADY, WREADY, ARREADY, {1'b1, g.resp, g.data});
      end
    end
    BREADY = !g.rd;
    RREADY = g.rd;
    @(negedge ACLK);
    BREADY = 1'b0;
    RREADY = 1'b0;
    n_cmp++;
    if (BVALID || RVALID) begin
      n_bad++;
      $display("FAIL rsp_release: got bvalid=%0b rvalid=%0b, required 0 0",
               BVALID, RVALID);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge ACLK);
    n_cmp++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID, cmd_valid, cmd_write,
         BRESP, RRESP, RDATA, cmd_data} !== '0) begin
      n_bad++;
      $display("FAIL reset_hold: got rdy=%b%b%b bv=%0b rv=%0b cv=%0b, required all 0",
               AWREADY, WREADY, ARREADY, BVALID, RVALID, cmd_valid);
    end
    ARESET = 1'b0;
    @(negedge ACLK);
    n_cmp++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID, cmd_valid} !== 6'b111000) begin
      n_bad++;
      $display("FAIL reset_release: got %b, required 111000",
               {AWREADY, WREADY, ARREADY, BVALID, RVALID, cmd_valid});
    end
  endtask

  task automatic test_single_write;
    int c0, v0, bc;
    c0 = hs_cnt;
    v0 = cv_cnt;
    eng_delay = LONG_E;
    exp_c(1'b1, 32'hA5A5_0F0F);
    exp_r(1'b0, 2'b00, 32'h0);
    axi_req(1, 1, 0, 32'h0100_0000, 32'hA5A5_0F0F, 4'hF, 32'h0);
    collect_rsp(LONG_E + 20, 3, bc);
    n_cmp++;
    if (bc !== rsp_cyc + 1) begin
      n_bad++;
      $display("FAIL b_latency: got cycle %0d, required %0d", bc, rsp_cyc + 1);
    end
    n_cmp++;
    if (hs_cnt - c0 != 1 || cv_cnt - v0 != 1) begin
      n_bad++;
      $display("FAIL cmd_beats: got hs=%0d cv=%0d, required 1 1",
               hs_cnt - c0, cv_cnt - v0);
    end
  endtask

  task automatic test_w_before_aw_then_read;
    int bc;
    bit ok;
    eng_delay = 5;
    eng_data = 32'h1234_5678;
    exp_c(1'b1, 32'h0F0F_1234);
    exp_c(1'b0, 32'h0);
    exp_r(1'b0, 2'b00, 32'h0);
    exp_r(1'b1, 2'b00, 32'h1234_5678);
    axi_req(0, 1, 0, 32'h0, 32'h0F0F_1234, 4'hF, 32'h0);
    repeat (2) @(negedge ACLK);
    axi_req(1, 0, 0, 32'h0100_0000, 32'h0, 4'h0, 32'h0);
    for (int i = 0; i < 10 && !cmd_valid; i++) @(negedge ACLK);
    ARADDR = 32'h0200_0000;
    ARVALID = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (ARREADY) ok = 1'b0;
      if (BVALID) break;
      @(negedge ACLK);
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL arready_during_write: got 1, required 0");
    end
    collect_rsp(5, 0, bc);
    axi_req(0, 0, 1, 32'h0, 32'h0, 4'h0, 32'h0200_0000);
    collect_rsp(30, 0, bc);
  endtask

  task automatic test_decode_errors;
    int v0, bc;
    v0 = cv_cnt;
    exp_r(1'b0, 2'b10, 32'h0);
    axi_req(1, 1, 0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0);
    collect_rsp(20, 0, bc);
    exp_r(1'b0, 2'b10, 32'h0);
    axi_req(1, 1, 0, 32'h0100_0000, 32'hDEAD_BEEF, 4'h3, 32'h0);
    collect_rsp(20, 0, bc);
    exp_r(1'b1, 2'b10, 32'h0);
    axi_req(0, 0, 1, 32'h0, 32'h0, 4'h0, 32'h0000_0040);
    collect_rsp(20, 0, bc);
    n_cmp++;
    if (cv_cnt != v0) begin
      n_bad++;
      $display("FAIL decode_no_cmd: got %0d cmd cycles, required 0", cv_cnt - v0);
    end
  endtask

  task automatic test_read_hold;
    int v0, bc;
    v0 = cv_cnt;
    eng_delay = 3;
    eng_data = 32'hCAFE_F00D;
    exp_c(1'b0, 32'h0);
    exp_r(1'b1, 2'b00, 32'hCAFE_F00D);
    axi_req(0, 0, 1, 32'h0, 32'h0, 4'h0, 32'h0200_0000);
    collect_rsp(20, 10, bc);
    n_cmp++;
    if (cv_cnt - v0 != 1) begin
      n_bad++;
      $display("FAIL read_hold_cmds: got %0d, required 1", cv_cnt - v0);
    end
  endtask

  task automatic test_back_to_back;
    int bc;
    eng_delay = 2;
    eng_data = 32'h0BAD_F00D;
    exp_c(1'b1, 32'h7777_8888);
    exp_c(1'b0, 32'h0);
    exp_r(1'b0, 2'b00, 32'h0);
    exp_r(1'b1, 2'b00, 32'h0BAD_F00D);
    axi_req(1, 1, 1, 32'h0100_0004, 32'h7777_8888, 4'hF, 32'h0200_0008);
    collect_rsp(20, 0, bc);
    collect_rsp(20, 0, bc);
  endtask

  task automatic test_stray_rsp;
    stray = 1'b1;
    repeat (5) @(negedge ACLK);
    n_cmp++;
    if (BVALID || RVALID || cmd_valid) begin
      n_bad++;
      $display("FAIL stray_rsp: got bv=%0b rv=%0b cv=%0b, required 0 0 0",
               BVALID, RVALID, cmd_valid);
    end
  endtask

  task automatic test_reset_mid_transfer;
    int c0;
    bit ok;
    c0 = hs_cnt;
    eng_delay = 100;
    exp_c(1'b1, 32'h5555_AAAA);
    axi_req(1, 1, 0, 32'h0100_0000, 32'h5555_AAAA, 4'hF, 32'h0);
    for (int i = 0; i < 10 && hs_cnt == c0; i++) @(negedge ACLK);
    repeat (3) @(negedge ACLK);
    #2 ARESET = 1'b1;
    #1;
    n_cmp++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID, cmd_valid, cmd_write,
         BRESP, RRESP, RDATA, cmd_data} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got rdy=%b%b%b bv=%0b cv=%0b cw=%0b, required all 0",
               AWREADY, WREADY, ARREADY, BVALID, cmd_valid, cmd_write);
    end
    @(negedge ACLK);
    #2 ARESET = 1'b0;
    @(negedge ACLK);
    ok = 1'b1;
    for (int i = 0; i < 120; i++) begin
      if (BVALID || RVALID) ok = 1'b0;
      @(negedge ACLK);
    end
    n_cmp++;
    if (!ok || {AWREADY, WREADY, ARREADY} !== 3'b111) begin
      n_bad++;
      $display("FAIL post_reset: got resp_seen=%0b rdy=%b%b%b, required 0 111",
               !ok, AWREADY, WREADY, ARREADY);
    end
  endtask

`ifdef SPI_BRIDGE_TIMEOUT_EN
  task automatic test_timeout;
    int bc;
    eng_en = 1'b0;
    exp_c(1'b0, 32'h0);
    exp_r(1'b1, 2'b10, 32'h0);
    axi_req(0, 0, 1, 32'h0, 32'h0, 4'h0, 32'h0200_0000);
    collect_rsp(40, 0, bc);
    n_cmp++;
    if (bc - hs_cyc != TO + 1) begin
      n_bad++;
      $display("FAIL timeout_latency: got %0d, required %0d", bc - hs_cyc, TO + 1);
    end
    eng_en = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_w_before_aw_then_read();
    test_decode_errors();
    test_read_hold();
    test_back_to_back();
    test_stray_rsp();
    test_reset_mid_transfer();
`ifdef SPI_BRIDGE_TIMEOUT_EN
    test_timeout();
`endif
    n_cmp++;
    if (exp_cmd.size() != 0 || exp_rsp.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got cmd=%0d rsp=%0d left, required 0 0",
               exp_cmd.size(), exp_rsp.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
